pc_branch_unit: RTL
===================

# pc_branch_unit

Parametrised program counter with an integrated conditional-branch decoder and a hardware call/return stack. It generalises the CPU's PC plus discrete jump-condition gating, so the controller drives a single condition-select field instead of one strobe per flag. It sits between the controller and the ALU result bus: it takes jump targets byte-wise from the result bus and drives the address used for instruction fetch. A registered `taken` output gives the CPU the "branch happened" qualifier it needs for gating the flags register clock.

## Interface
- `AWIDTH`, 16, PC width in bits. Must be >8. Target high part is `AWIDTH-8` bits.
- `NFLAGS`, 10, number of active-low condition flags.
- `SEL_W`, 4, width of `cond_sel`. Must be ≥ clog2(NFLAGS).
- `STACK_DEPTH`, 4, return-stack entries. Must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `_mr`  in  1  reset, synchronous, active-low.
- `D`  in  8  data byte from the ALU result bus.
- `_pchitmp_in`  in  1  active-low; load `D` into the low 8 bits of `hitmp`.
- `_pclo_in`  in  1  active-low; load `D` into the PC low byte only.
- `_pc_in`  in  1  active-low unconditional jump to `{hitmp, D}`.
- `_cond_in`  in  1  active-low conditional jump to `{hitmp, D}`.
- `cond_sel`  in  SEL_W  flag index tested by `_cond_in`.
- `cond_inv`  in  1  when 1, the jump is taken if the selected flag is inactive.
- `_flags`  in  NFLAGS  active-low flags from the flags register.
- `_call_in`  in  1  active-low; push return address and jump to `{hitmp, D}`.
- `_ret_in`  in  1  active-low; pop the stack into the PC.
- `_hold`  in  1  active-low stall; PC does not increment.
- `pc`  out  AWIDTH  current program counter.
- `taken`  out  1  registered; PC was loaded non-sequentially on the last edge (jump, call, ret, or pclo).
- `stack_empty`  out  1  stack count is 0.
- `stack_full`  out  1  stack count equals `STACK_DEPTH`.
- `stack_err`  out  1  sticky overflow/underflow indicator.

## Operation
- **Conditional decode:** `cond_true = (cond_sel < NFLAGS) & ((!_flags[cond_sel]) ^ cond_inv)`. If `cond_sel ≥ NFLAGS`, the jump is never taken, regardless of `cond_inv`.
- **Jump-taken condition:** `jt = !_pc_in | (!_cond_in & cond_true)`.
- **Next-PC priority**, one action per edge:
  1. `_mr` = 0: reset.
  2. `_ret_in` = 0 and stack not empty: `pc` ← top of stack; pop.
  3. `_ret_in` = 0 and stack empty: `stack_err` ← 1; `pc` behaves as if no control input were asserted (increment or hold).
  4. `_call_in` = 0: push `pc+1` (mod 2^AWIDTH); `pc` ← `{hitmp, D}`.
     - If stack full: no push, stack contents unchanged, `stack_err` ← 1, jump still performed.
  5. `jt`: `pc` ← `{hitmp, D}`.
  6. `_pclo_in` = 0: `pc[7:0]` ← `D`; upper bits unchanged.
  7. `_hold` = 0: `pc` unchanged.
  8. Otherwise: `pc` ← `pc+1`, wrapping from all-ones to 0.
- **Simultaneous call and ret:** ret wins and the call is ignored (no push).
- **hitmp load:** `_pchitmp_in` is independent of the priority chain. A load on the same edge as a jump does not affect that jump, which uses the old `hitmp`.
- **taken:** set to 1 on edges that take rows 2, 4, 5 or 6; cleared to 0 on every other edge.
- **Stack:** a LIFO with a count of 0..STACK_DEPTH. `stack_empty` and `stack_full` are derived combinationally from the registered count.
- **stack_err:** cleared only by `_mr`.

## Timing
- All outputs are registered or derived from registers; there is no combinational path from inputs to outputs.
- Control inputs, `D`, `_flags` and `cond_sel` are sampled on the same rising edge. The new `pc` is visible after that edge (1-cycle latency).
- **Reset values:** `pc`=0, `hitmp`=0, count=0, `stack_empty`=1, `stack_full`=0, `stack_err`=0, `taken`=0.
- **Stack contents:** unspecified after reset.
- **Reset mid-call:** reset has priority; no push occurs on that edge.
- **Back-to-back call/ret:** a call followed by a ret on the next edge returns to the call address + 1.
- **Push and pop:** each completes in a single edge.

## Test plan
- **Reset and increment:** `_mr`=0 for one edge → `pc`=0, `stack_empty`=1. Release with no controls for 3 edges → `pc`=3, `taken`=0.
- **Wrap and hold:**
  - Load `pc`=0xFFFF via `hitmp`=0xFF, `D`=0xFF, `_pc_in`. Next edge → `pc`=0x0000.
  - `_hold`=0 → `pc` stays 0x0000.
- **Conditional jump:** `hitmp`=0x12, `D`=0x34, `cond_sel`=2.
  - `_flags[2]`=0, `cond_inv`=0 → `pc`=0x1234, `taken`=1.
  - `_flags[2]`=1 → `pc` increments.
  - `cond_inv`=1 inverts both cases.
  - `cond_sel`=12 → never taken.
- **pclo and same-edge hitmp:**
  - `pc`=0x1234; `_pclo_in` with `D`=0x80 → `pc`=0x1280.
  - `_pchitmp_in` (`D`=0x55) together with `_pc_in` (`D`=0x55) while `hitmp`=0x12 → `pc`=0x1255. A later jump uses `hitmp`=0x55.
- **Call/return nesting:**
  - From `pc`=0x0010: call 0x0100, then call 0x0200 → stack holds 0x0011 and 0x0101.
  - Ret → `pc`=0x0101. Ret → `pc`=0x0011, `stack_empty`=1.
- **Overflow/underflow:**
  - `STACK_DEPTH`+1 calls → `stack_full`=1, `stack_err`=1, last jump taken, earlier entries intact.
  - Ret on empty stack → `stack_err`=1 and `pc` increments.
  - Only `_mr` clears `stack_err`.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter with condition-select branch decode and a hardware call/return stack.
// Jump targets are assembled from the hitmp register and the result-bus byte.
module pc_branch_unit #(
  parameter int unsigned AWIDTH      = 16,
  parameter int unsigned NFLAGS      = 10,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              _mr,
  input  logic [7:0]        D,
  input  logic              _pchitmp_in,
  input  logic              _pclo_in,
  input  logic              _pc_in,
  input  logic              _cond_in,
  input  logic [SEL_W-1:0]  cond_sel,
  input  logic              cond_inv,
  input  logic [NFLAGS-1:0] _flags,
  input  logic              _call_in,
  input  logic              _ret_in,
  input  logic              _hold,
  output logic [AWIDTH-1:0] pc,
  output logic              taken,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  localparam int unsigned HW = AWIDTH - 8;
  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [HW-1:0]     hitmp_q, hitmp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              taken_q, taken_d;
  logic              err_q, err_d;
  logic [AWIDTH-1:0] stack_q [STACK_DEPTH];
  logic [AWIDTH-1:0] stack_d [STACK_DEPTH];

  logic [AWIDTH-1:0] pc_inc, pc_seq, target, top;
  logic [HW+7:0]     d_wide;
  logic              sel_valid, flag_sel_n, cond_true, jt, empty, full;

  assign pc_inc = pc_q + AWIDTH'(1);
  assign pc_seq = _hold ? pc_inc : pc_q;
  assign target = {hitmp_q, D};
  assign d_wide = {{HW{1'b0}}, D};
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(STACK_DEPTH));

  // Out-of-range selects match no flag, so the condition is never true.
  always_comb begin
    sel_valid  = 1'b0;
    flag_sel_n = 1'b1;
    for (int unsigned i = 0; i < NFLAGS; i++) begin
      if (cond_sel == SEL_W'(i)) begin
        sel_valid  = 1'b1;
        flag_sel_n = _flags[i];
      end
    end
  end

  assign cond_true = sel_valid & (~flag_sel_n ^ cond_inv);
  assign jt        = ~_pc_in | (~_cond_in & cond_true);

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == CW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    hitmp_d = hitmp_q;
    if (!_pchitmp_in) begin
      for (int unsigned i = 0; i < HW; i++) begin
        if (i < 8) hitmp_d[i] = d_wide[i];
      end
    end
  end

  always_comb begin
    pc_d    = pc_seq;
    count_d = count_q;
    taken_d = 1'b0;
    err_d   = err_q;
    stack_d = stack_q;
    if (!_ret_in) begin
      if (!empty) begin
        pc_d    = top;
        count_d = count_q - CW'(1);
        taken_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (!_call_in) begin
      pc_d    = target;
      taken_d = 1'b1;
      if (full) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
          if (count_q == CW'(i)) stack_d[i] = pc_inc;
        end
      end
    end else if (jt) begin
      pc_d    = target;
      taken_d = 1'b1;
    end else if (!_pclo_in) begin
      pc_d    = {pc_q[AWIDTH-1:8], D};
      taken_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!_mr) begin
      pc_q    <= '0;
      hitmp_q <= '0;
      count_q <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      hitmp_q <= hitmp_d;
      count_q <= count_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  // Entries are only meaningful below count_q, so they need no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc          = pc_q;
  assign taken       = taken_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_err   = err_q;

endmodule
